// File: rtl/a1_pkg.sv
// Shared types and helpers for the A1 clip sequencer.
// Holds the FSM state encoding, default widths and the window test.
package a1_pkg;

    localparam int PW_DEF = 16;
    localparam int WW_DEF = 15;
    localparam int CW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INNER,
        OUTER,
        DONE
    } state_e;

    // A pixel is outside when either coordinate is negative or
    // reaches the window size.
    function automatic logic is_outside(
        input logic x_neg,
        input logic x_ge,
        input logic y_neg,
        input logic y_ge
    );
        return x_neg | x_ge | y_neg | y_ge;
    endfunction

endpackage

// File: rtl/a1_clip_seq_win_cmp.sv
// A1 window comparator: flags a pointer lying outside win_x/win_y.
// Purely combinational; the sign bit marks a negative coordinate.
module a1_win_cmp
    import a1_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic [PW-1:0] x,
    input  logic [PW-1:0] y,
    input  logic [WW-1:0] win_x,
    input  logic [WW-1:0] win_y,
    output logic          outside
);

    logic x_ge;
    logic y_ge;

    // Unsigned compare: a coordinate equal to the size is outside.
    always_comb begin
        x_ge    = (x[WW-1:0] >= win_x);
        y_ge    = (y[WW-1:0] >= win_y);
        outside = is_outside(x[PW-1], x_ge, y[PW-1], y_ge);
    end

endmodule

// File: rtl/a1_clip_seq.sv
// A1 rectangle sequencer: steps X inside Y and issues clipped pixels.
// Optional clip_cnt output is enabled by defining A1_CLIP_COUNT_EN.
module a1_clip_seq
    import a1_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int WW = WW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] x_init,
    input  logic [PW-1:0] y_init,
    input  logic [PW-1:0] x_step,
    input  logic [PW-1:0] x_ostep,
    input  logic [PW-1:0] y_step,
    input  logic [CW-1:0] inner_cnt,
    input  logic [CW-1:0] outer_cnt,
    input  logic [WW-1:0] win_x,
    input  logic [WW-1:0] win_y,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [PW-1:0] pix_x,
    output logic [PW-1:0] pix_y,
    output logic          pix_write,
    output logic          done
`ifdef A1_CLIP_COUNT_EN
    ,
    output logic [CW-1:0] clip_cnt
`endif
);

    state_e        state_q, state_d;
    logic [PW-1:0] x_q, x_d;
    logic [PW-1:0] y_q, y_d;
    logic [PW-1:0] row_x_q, row_x_d;
    logic [CW-1:0] icnt_q, icnt_d;
    logic [CW-1:0] ocnt_q, ocnt_d;
    logic          drain_q, drain_d;

    logic [PW-1:0] x_init_q, x_init_d;
    logic [PW-1:0] y_init_q, y_init_d;
    logic [PW-1:0] x_step_q, x_step_d;
    logic [PW-1:0] x_ostep_q, x_ostep_d;
    logic [PW-1:0] y_step_q, y_step_d;
    logic [CW-1:0] inner_q, inner_d;
    logic [CW-1:0] outer_q, outer_d;
    logic [WW-1:0] win_x_q, win_x_d;
    logic [WW-1:0] win_y_q, win_y_d;

`ifdef A1_CLIP_COUNT_EN
    logic [CW-1:0] clip_q, clip_d;
`endif

    logic outside;
    logic accept;
    logic empty;

    a1_win_cmp #(
        .PW(PW),
        .WW(WW)
    ) u_win_cmp (
        .x      (x_q),
        .y      (y_q),
        .win_x  (win_x_q),
        .win_y  (win_y_q),
        .outside(outside)
    );

    // Moore outputs decoded straight from the state register.
    always_comb begin
        pix_valid = (state_q == INNER);
        pix_write = pix_valid & ~outside;
        busy      = (state_q == LOAD) | (state_q == INNER) |
                    (state_q == OUTER);
        done      = (state_q == DONE);
        pix_x     = x_q;
        pix_y     = y_q;
        accept    = pix_valid & pix_ready;
        empty     = (inner_q == '0) | (outer_q == '0);
`ifdef A1_CLIP_COUNT_EN
        clip_cnt  = clip_q;
`endif
    end

    // Next-state, pointer and loop-counter logic.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        row_x_d   = row_x_q;
        icnt_d    = icnt_q;
        ocnt_d    = ocnt_q;
        drain_d   = drain_q;
        x_init_d  = x_init_q;
        y_init_d  = y_init_q;
        x_step_d  = x_step_q;
        x_ostep_d = x_ostep_q;
        y_step_d  = y_step_q;
        inner_d   = inner_q;
        outer_d   = outer_q;
        win_x_d   = win_x_q;
        win_y_d   = win_y_q;
`ifdef A1_CLIP_COUNT_EN
        clip_d    = clip_q;
        if (accept && !pix_write) begin
            clip_d = clip_q + CW'(1);
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_init_d  = x_init;
                    y_init_d  = y_init;
                    x_step_d  = x_step;
                    x_ostep_d = x_ostep;
                    y_step_d  = y_step;
                    inner_d   = inner_cnt;
                    outer_d   = outer_cnt;
                    win_x_d   = win_x;
                    win_y_d   = win_y;
                    drain_d   = 1'b0;
`ifdef A1_CLIP_COUNT_EN
                    clip_d    = '0;
`endif
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Empty commands linger one extra LOAD cycle so
                // their done pulse lands a fixed 3 cycles after start.
                if (empty) begin
                    drain_d = ~drain_q;
                    if (drain_q) begin
                        state_d = DONE;
                    end
                end else begin
                    x_d     = x_init_q;
                    row_x_d = x_init_q;
                    y_d     = y_init_q;
                    icnt_d  = inner_q;
                    ocnt_d  = outer_q;
                    state_d = INNER;
                end
            end
            INNER: begin
                if (accept) begin
                    if (icnt_q > CW'(1)) begin
                        x_d    = x_q + x_step_q;
                        icnt_d = icnt_q - CW'(1);
                    end else if (ocnt_q > CW'(1)) begin
                        state_d = OUTER;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            OUTER: begin
                row_x_d = row_x_q + x_ostep_q;
                x_d     = row_x_q + x_ostep_q;
                y_d     = y_q + y_step_q;
                icnt_d  = inner_q;
                ocnt_d  = ocnt_q - CW'(1);
                state_d = INNER;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_x_q   <= '0;
            icnt_q    <= '0;
            ocnt_q    <= '0;
            drain_q   <= 1'b0;
            x_init_q  <= '0;
            y_init_q  <= '0;
            x_step_q  <= '0;
            x_ostep_q <= '0;
            y_step_q  <= '0;
            inner_q   <= '0;
            outer_q   <= '0;
            win_x_q   <= '0;
            win_y_q   <= '0;
`ifdef A1_CLIP_COUNT_EN
            clip_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_x_q   <= row_x_d;
            icnt_q    <= icnt_d;
            ocnt_q    <= ocnt_d;
            drain_q   <= drain_d;
            x_init_q  <= x_init_d;
            y_init_q  <= y_init_d;
            x_step_q  <= x_step_d;
            x_ostep_q <= x_ostep_d;
            y_step_q  <= y_step_d;
            inner_q   <= inner_d;
            outer_q   <= outer_d;
            win_x_q   <= win_x_d;
            win_y_q   <= win_y_d;
`ifdef A1_CLIP_COUNT_EN
            clip_q    <= clip_d;
`endif
        end
    end

endmodule

// File: tb/tb_a1_clip_seq.sv
// Directed bench for a1_clip_seq with hand-computed expectations.
// Define A1_CLIP_COUNT_EN to also check clip_cnt.
module tb_a1_clip_seq;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x_init, y_init, x_step, x_ostep, y_step;
    logic [15:0] inner_cnt, outer_cnt;
    logic [14:0] win_x, win_y;
    logic        busy, pix_valid, pix_ready, pix_write, done;
    logic [15:0] pix_x, pix_y;
`ifdef A1_CLIP_COUNT_EN
    logic [15:0] clip_cnt;
`endif

    int checks = 0;
    int errors = 0;

    a1_clip_seq dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .start    (start),
        .x_init   (x_init),
        .y_init   (y_init),
        .x_step   (x_step),
        .x_ostep  (x_ostep),
        .y_step   (y_step),
        .inner_cnt(inner_cnt),
        .outer_cnt(outer_cnt),
        .win_x    (win_x),
        .win_y    (win_y),
        .busy     (busy),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_write(pix_write),
        .done     (done)
`ifdef A1_CLIP_COUNT_EN
        ,
        .clip_cnt (clip_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_px(input string t, input logic [15:0] ex,
                            input logic [15:0] ey, input logic ew);
        chk({t, ".valid"}, 32'(pix_valid), 32'd1);
        chk({t, ".x"}, 32'(pix_x), 32'(ex));
        chk({t, ".y"}, 32'(pix_y), 32'(ey));
        chk({t, ".write"}, 32'(pix_write), 32'(ew));
    endtask

    task automatic set_cmd(input logic [15:0] xi, input logic [15:0] yi,
                           input logic [15:0] xs, input logic [15:0] xo,
                           input logic [15:0] ys, input logic [15:0] ic,
                           input logic [15:0] oc, input logic [14:0] wx,
                           input logic [14:0] wy);
        x_init = xi; y_init = yi; x_step = xs; x_ostep = xo;
        y_step = ys; inner_cnt = ic; outer_cnt = oc;
        win_x = wx; win_y = wy;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 4x2 rectangle from (0,0); pixels with x >= wx are clipped.
    task automatic run_4x2(input string t, input int wx);
        set_cmd(16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd4, 16'd2,
                15'(wx), 15'd100);
        go();
        chk({t, ".busy_load"}, 32'(busy), 32'd1);
        chk({t, ".valid_load"}, 32'(pix_valid), 32'd0);
        win_x = 15'd0;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                check_px($sformatf("%s.r%0dp%0d", t, r, i),
                         16'(i), 16'(r), logic'(i < wx));
                tick();
            end
            if (r == 0) begin
                chk({t, ".bubble"}, 32'(pix_valid), 32'd0);
                chk({t, ".bubble_busy"}, 32'(busy), 32'd1);
                tick();
            end
        end
        chk({t, ".done"}, 32'(done), 32'd1);
        chk({t, ".busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({t, ".done_low"}, 32'(done), 32'd0);
    endtask

    logic [15:0] xv;
    logic [3:0]  ew;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pix_ready = 1'b1;
        set_cmd('0, '0, '0, '0, '0, '0, '0, '0, '0);
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(pix_valid), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.write", 32'(pix_write), 32'd0);
        chk("rst.x", 32'(pix_x), 32'd0);
        chk("rst.y", 32'(pix_y), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_4x2("t1", 100);
        tick();
        run_4x2("t2", 2);
`ifdef A1_CLIP_COUNT_EN
        chk("t2.clip_cnt", 32'(clip_cnt), 32'd4);
`endif
        tick();

        // X wraps through the sign bit: negative pixels are clipped.
        set_cmd(16'hFFFE, 16'd0, 16'd1, 16'd0, 16'd1, 16'd4, 16'd1,
                15'd10, 15'd10);
        go();
        tick();
        xv = 16'hFFFE;
        ew = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            check_px($sformatf("t3.p%0d", i), xv, 16'd0, ew[i]);
            xv = xv + 16'd1;
            tick();
        end
        chk("t3.done", 32'(done), 32'd1);
        tick();

        // Backpressure on the third pixel.
        set_cmd(16'd0, 16'd5, 16'd1, 16'd0, 16'd1, 16'd4, 16'd1,
                15'd100, 15'd100);
        go();
        tick();
        check_px("t4.p0", 16'd0, 16'd5, 1'b1);
        tick();
        check_px("t4.p1", 16'd1, 16'd5, 1'b1);
        tick();
        pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_px($sformatf("t4.hold%0d", k), 16'd2, 16'd5, 1'b1);
            tick();
        end
        pix_ready = 1'b1;
        check_px("t4.p2", 16'd2, 16'd5, 1'b1);
        tick();
        check_px("t4.p3", 16'd3, 16'd5, 1'b1);
        tick();
        chk("t4.done", 32'(done), 32'd1);
        chk("t4.valid_done", 32'(pix_valid), 32'd0);
        tick();

        // Empty command; a second start while busy is ignored.
        set_cmd(16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd2,
                15'd100, 15'd100);
        go();
        chk("t5.busy1", 32'(busy), 32'd1);
        chk("t5.valid1", 32'(pix_valid), 32'd0);
        inner_cnt = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.valid2", 32'(pix_valid), 32'd0);
        chk("t5.done2", 32'(done), 32'd0);
        tick();
        chk("t5.done3", 32'(done), 32'd1);
        chk("t5.valid3", 32'(pix_valid), 32'd0);
        chk("t5.busy3", 32'(busy), 32'd0);
        tick();
        chk("t5.done4", 32'(done), 32'd0);
        tick();
        chk("t5.idle", 32'(busy), 32'd0);
        chk("t5.idle_valid", 32'(pix_valid), 32'd0);

        // Reset during the second row; x_ostep shifts row start.
        set_cmd(16'd0, 16'd0, 16'd1, 16'd3, 16'd1, 16'd4, 16'd2,
                15'd100, 15'd100);
        go();
        tick();
        for (int i = 0; i < 4; i++) begin
            check_px($sformatf("t6.r0p%0d", i), 16'(i), 16'd0, 1'b1);
            tick();
        end
        tick();
        check_px("t6.r1p0", 16'd3, 16'd1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.valid", 32'(pix_valid), 32'd0);
        chk("t6.done", 32'(done), 32'd0);
        chk("t6.write", 32'(pix_write), 32'd0);
        chk("t6.x", 32'(pix_x), 32'd0);
        chk("t6.y", 32'(pix_y), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6.nodone%0d", k), 32'(done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
